// File: rtl/shift_count_param.sv
// shift_count_param: serial-load shift register with a prescaled up/down counter.
//   WIDTH    : register width (>= 2)
//   PRESCALE : qualifying count_ena cycles per counter step (>= 1)
// Ports:
//   clk, resetn (sync, active-low), shift_ena, count_ena, dir (0 down / 1 up),
//   data (serial in, MSB first), q (registered value), tc (terminal count,
//   combinational), wrap (registered one-cycle pulse after a wrapping step).
// Optional build macro: SHIFTCOUNT_SAT_EN -- saturate instead of wrapping; wrap tied low.
module shift_count_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             shift_ena,
  input  logic             count_ena,
  input  logic             dir,
  input  logic             data,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_val;
  logic             at_edge;

  always_comb begin
    step_val = dir ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
    at_edge  = dir ? (q_q == '1) : (q_q == '0);
  end

  always_comb begin
    q_d    = q_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    if (shift_ena) begin
      q_d    = {q_q[WIDTH-2:0], data};
      pcnt_d = '0;
    end else if (count_ena) begin
      if (pcnt_q == PLAST) begin
        pcnt_d = '0;
`ifdef SHIFTCOUNT_SAT_EN
        if (!at_edge) q_d = step_val;
`else
        q_d    = step_val;
        wrap_d = at_edge;
`endif
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q    <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = at_edge;

endmodule

// File: tb/tb_shift_count_param.sv
module tb_shift_count_param;

  logic       clk = 1'b0;
  logic       resetn, shift_ena, count_ena, dir, data;
  logic [3:0] q4, q3;
  logic [7:0] q8;
  logic       tc4, tc3, tc8, w4, w3, w8;
  int         nerr = 0;
  int         nchk = 0;

  localparam int MW [3] = '{4, 4, 8};
  localparam int MP [3] = '{1, 3, 3};
  int mv [3];
  int mp [3];
  int mw [3];

  always #5 clk = ~clk;

  shift_count_param #(.WIDTH(4), .PRESCALE(1)) u_w4p1 (
    .clk(clk), .resetn(resetn), .shift_ena(shift_ena), .count_ena(count_ena),
    .dir(dir), .data(data), .q(q4), .tc(tc4), .wrap(w4));
  shift_count_param #(.WIDTH(4), .PRESCALE(3)) u_w4p3 (
    .clk(clk), .resetn(resetn), .shift_ena(shift_ena), .count_ena(count_ena),
    .dir(dir), .data(data), .q(q3), .tc(tc3), .wrap(w3));
  shift_count_param #(.WIDTH(8), .PRESCALE(3)) u_w8p3 (
    .clk(clk), .resetn(resetn), .shift_ena(shift_ena), .count_ena(count_ena),
    .dir(dir), .data(data), .q(q8), .tc(tc8), .wrap(w8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: integer value, modulo 2^W arithmetic, counting of enables.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int m, nv;
      bit crossed;
      m = 1 << MW[i];
      if (!resetn) begin
        mv[i] = 0; mp[i] = 0; mw[i] = 0;
      end else if (shift_ena) begin
        mv[i] = (mv[i] * 2 + int'(data)) % m;
        mp[i] = 0; mw[i] = 0;
      end else if (count_ena) begin
        mw[i] = 0;
        if (mp[i] + 1 == MP[i]) begin
          mp[i] = 0;
          nv = dir ? mv[i] + 1 : mv[i] - 1;
          crossed = (nv < 0) || (nv >= m);
`ifdef SHIFTCOUNT_SAT_EN
          if (!crossed) mv[i] = nv;
`else
          mv[i] = (nv + m) % m;
          mw[i] = int'(crossed);
`endif
        end else begin
          mp[i] = mp[i] + 1;
        end
      end else begin
        mw[i] = 0;
      end
    end
  endtask

  function automatic int model_tc(input int i);
    return dir ? int'(mv[i] == (1 << MW[i]) - 1) : int'(mv[i] == 0);
  endfunction

  task automatic check_all();
    chk("q_w4p1", 32'(q4), 32'(mv[0]));
    chk("q_w4p3", 32'(q3), 32'(mv[1]));
    chk("q_w8p3", 32'(q8), 32'(mv[2]));
    chk("wrap_w4p1", 32'(w4), 32'(mw[0]));
    chk("wrap_w4p3", 32'(w3), 32'(mw[1]));
    chk("wrap_w8p3", 32'(w8), 32'(mw[2]));
    chk("tc_w4p1", 32'(tc4), 32'(model_tc(0)));
    chk("tc_w4p3", 32'(tc3), 32'(model_tc(1)));
    chk("tc_w8p3", 32'(tc8), 32'(model_tc(2)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic shift_in(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shift_ena = 1'b1;
      data = 1'((v >> i) & 1);
      tick();
    end
    shift_ena = 1'b0;
    data = 1'b0;
  endtask

  task automatic count(input int n);
    count_ena = 1'b1;
    for (int i = 0; i < n; i++) tick();
    count_ena = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 0; mp[i] = 0; mw[i] = 0; end
    resetn = 1'b0; shift_ena = 1'b0; count_ena = 1'b0; dir = 1'b0; data = 1'b0;
    tick(); tick();
    chk("reset_q", 32'(q4), 0);
    chk("reset_tc", 32'(tc4), 1);
    resetn = 1'b1;

    // Legacy sequence
    shift_in(4'b1011, 4);
    chk("legacy_load", 32'(q4), 11);
    count(1); chk("legacy_c1", 32'(q4), 10);
    count(1); chk("legacy_c2", 32'(q4), 9);
    count(1); chk("legacy_c3", 32'(q4), 8);

    // Wrap and tc, down then up
    shift_in(1, 4);
    count(1); chk("down_to0", 32'(q4), 0); chk("down_to0_tc", 32'(tc4), 1);
    count(1);
`ifdef SHIFTCOUNT_SAT_EN
    chk("down_sat_q", 32'(q4), 0); chk("down_sat_wrap", 32'(w4), 0);
`else
    chk("down_wrap_q", 32'(q4), 15); chk("down_wrap_pulse", 32'(w4), 1);
`endif
    tick(); chk("down_wrap_end", 32'(w4), 0);
    shift_in(15, 4);
    dir = 1'b1;
    count(1);
`ifdef SHIFTCOUNT_SAT_EN
    chk("up_sat_q", 32'(q4), 15); chk("up_sat_wrap", 32'(w4), 0);
`else
    chk("up_wrap_q", 32'(q4), 0); chk("up_wrap_pulse", 32'(w4), 1);
`endif
    tick();

    // Prescaler (PRESCALE=3, up)
    shift_in(2, 4);
    count(2); tick(); tick();
    count(1); chk("pre_e3", 32'(q3), 3);
    count(3); chk("pre_e6", 32'(q3), 4);
    count(1); chk("pre_e7", 32'(q3), 4);

    // Priority: both enables high shifts and clears the prescaler
    shift_in(2, 4);
    count(2); chk("prio_nostep", 32'(q3), 2);
    shift_ena = 1'b1; count_ena = 1'b1; data = 1'b1;
    tick();
    shift_ena = 1'b0; count_ena = 1'b0; data = 1'b0;
    chk("prio_shift", 32'(q3), 5);
    count(2); chk("prio_hold", 32'(q3), 5);
    count(1); chk("prio_step", 32'(q3), 6);

    // Reset mid-operation on the 8-bit instance
    dir = 1'b0;
    shift_in(8'hA5, 8);
    count(1); chk("mid_hold", 32'(q8), 8'hA5);
    resetn = 1'b0; count_ena = 1'b1;
    tick();
    resetn = 1'b1; count_ena = 1'b0;
    chk("mid_rst_q", 32'(q8), 0); chk("mid_rst_wrap", 32'(w8), 0);
    chk("mid_rst_tc", 32'(tc8), 1);
    dir = 1'b1;
    count(2); chk("mid_rst_pre2", 32'(q8), 0);
    count(1); chk("mid_rst_pre3", 32'(q8), 1);

    // Direction flip with no clock edge
    dir = 1'b0;
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("flip_tc_before", 32'(tc4), 1);
    dir = 1'b1;
    #1;
    chk("flip_tc_after", 32'(tc4), 0);
    count(1); chk("flip_q", 32'(q4), 1); chk("flip_wrap", 32'(w4), 0);

    // Random legacy-style traffic, dir fixed at 0
    dir = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      shift_ena = 1'($urandom_range(0, 3) == 0);
      count_ena = 1'($urandom);
      data      = 1'($urandom);
      tick();
    end

    // Random traffic with direction changes and occasional reset
    for (int n = 0; n < 600; n++) begin
      shift_ena = 1'($urandom_range(0, 4) == 0);
      count_ena = 1'($urandom);
      data      = 1'($urandom);
      dir       = 1'($urandom_range(0, 7) != 0 ? dir : ~dir);
      resetn    = 1'($urandom_range(0, 39) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
